fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch unit for Raisin64. It issues sequential aligned 64-bit memory requests with several reads in flight, and buffers the returned words in a DEPTH-word byte queue. It presents the decoder a 64-bit little-endian window starting at the current PC, which the decoder consumes in 2/4/8-byte steps. It also supports PC redirect (branch/trap), including squashing of in-flight responses.

---
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Raisin64 instruction fetch queue: streams aligned 64-bit reads into a word queue
// and presents the decoder an 8-byte little-endian window at the current PC.
module fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_addr_valid,
    input  logic              imem_addr_ready,
    input  logic [63:0]       imem_data,
    input  logic              imem_data_valid,
    output logic [63:0]       instData,
    output logic [3:0]        inst_bytes,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              advance16,
    input  logic              advance32,
    input  logic              advance64,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              adv_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W = $clog2(DEPTH + MAX_OUT + 1);
    localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(DEPTH);
    localparam logic [OUT_W-1:0] OUT_LIM   = OUT_W'(MAX_OUT);

    logic [63:0]       queue_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  words;
    logic [2:0]        head_off;
    logic [OUT_W-1:0]  inflight;
    logic [OUT_W-1:0]  drop_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pc;
    logic              err_q;

    logic [SUM_W-1:0]  occupancy;
    logic              issue;
    logic              accept_word;
    logic [1:0]        adv_cnt;
    logic [3:0]        adv_size;
    logic              adv_any;
    logic              adv_legal;
    logic [3:0]        off_sum;
    logic              free_word;
    logic [PTR_W-1:0]  next_ptr;
    logic [127:0]      pair;
    logic [127:0]      shifted;
    logic [63:0]       byte_mask;
    logic [ADDR_W-1:0] redirect_even;

    assign occupancy       = SUM_W'(words) + SUM_W'(inflight);
    assign imem_addr_valid = rst_n && !redirect_valid && (occupancy < DEPTH_LIM) && (inflight < OUT_LIM);
    assign imem_addr       = fetch_addr;
    assign issue           = imem_addr_valid && imem_addr_ready;
    assign accept_word     = imem_data_valid && (drop_cnt == '0);
    assign inst_pc         = pc;
    assign adv_err         = err_q;
    assign redirect_even   = redirect_pc & ~ADDR_W'(1);

    // Window size: two or more buffered words always cover 8 bytes past head_off.
    always_comb begin
        if (words == '0) begin
            inst_bytes = 4'd0;
        end else if (words == CNT_W'(1)) begin
            inst_bytes = 4'd8 - {1'b0, head_off};
        end else begin
            inst_bytes = 4'd8;
        end
    end

    assign next_ptr = head + PTR_W'(1);
    assign pair     = {queue_mem[next_ptr], queue_mem[head]};
    assign shifted  = pair >> {head_off, 3'b000};

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[8*i +: 8] = (4'(i) < inst_bytes) ? 8'hFF : 8'h00;
        end
    end

    assign instData = shifted[63:0] & byte_mask;

    always_comb begin
        adv_cnt  = {1'b0, advance16} + {1'b0, advance32} + {1'b0, advance64};
        adv_any  = advance16 || advance32 || advance64;
        adv_size = advance64 ? 4'd8 : (advance32 ? 4'd4 : 4'd2);
        adv_legal = (adv_cnt == 2'd1) && (adv_size <= inst_bytes);
        off_sum   = {1'b0, head_off} + adv_size;
        free_word = adv_legal && off_sum[3];
    end

    // Responses landing during a redirect are stale and never written.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && accept_word) begin
            queue_mem[tail] <= imem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            words      <= '0;
            head_off   <= RESET_PC[2:0];
            inflight   <= '0;
            drop_cnt   <= '0;
            fetch_addr <= RESET_PC & ~ADDR_W'(7);
            pc         <= RESET_PC;
            err_q      <= 1'b0;
        end else if (redirect_valid) begin
            // Every response still outstanding now belongs to the abandoned stream.
            head       <= '0;
            tail       <= '0;
            words      <= '0;
            head_off   <= redirect_even[2:0];
            inflight   <= inflight - OUT_W'(imem_data_valid);
            drop_cnt   <= inflight - OUT_W'(imem_data_valid);
            fetch_addr <= redirect_even & ~ADDR_W'(7);
            pc         <= redirect_even;
            err_q      <= 1'b0;
        end else begin
            tail     <= tail + PTR_W'(accept_word);
            head     <= head + PTR_W'(free_word);
            words    <= words + CNT_W'(accept_word) - CNT_W'(free_word);
            inflight <= inflight + OUT_W'(issue) - OUT_W'(imem_data_valid);
            drop_cnt <= drop_cnt - OUT_W'(imem_data_valid && (drop_cnt != '0));
            if (issue) begin
                fetch_addr <= fetch_addr + ADDR_W'(8);
            end
            if (adv_legal) begin
                head_off <= off_sum[2:0];
                pc       <= pc + ADDR_W'(adv_size);
            end
            err_q <= adv_any && !adv_legal;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a byte-address model of the fetch stream
// plus an in-order memory with random latency, checked every cycle.
module tb_fetch_queue;
    localparam int          ADDR_W   = 64;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic        imem_addr_ready;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic [63:0] instData;
    logic [3:0]  inst_bytes;
    logic [63:0] inst_pc;
    logic        advance16;
    logic        advance32;
    logic        advance64;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        adv_err;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid), .imem_addr_ready(imem_addr_ready),
        .imem_data(imem_data), .imem_data_valid(imem_data_valid),
        .instData(instData), .inst_bytes(inst_bytes), .inst_pc(inst_pc),
        .advance16(advance16), .advance32(advance32), .advance64(advance64),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .adv_err(adv_err)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    req_t        pending[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rand_lat = 1'b0;

    // Model: PC, end of buffered bytes, next fetch address, outstanding and stale counts.
    logic [63:0] m_pc;
    logic [63:0] m_buf_end;
    logic [63:0] m_fetch;
    int          m_inflight;
    int          m_drop;
    bit          m_err;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [63:0] wordAt(input logic [63:0] a);
        logic [63:0] al;
        al = a & ~64'h7;
        return {al[31:0], ~al[31:0]};
    endfunction

    function automatic int modelWords();
        logic [63:0] diff;
        diff = m_buf_end - (m_pc & ~64'h7);
        return int'(diff >> 3);
    endfunction

    function automatic int modelBytes();
        int w;
        w = modelWords();
        if (w == 0) return 0;
        if (w >= 2) return 8;
        return 8 - int'(m_pc[2:0]);
    endfunction

    function automatic logic [63:0] modelData();
        logic [63:0] d;
        logic [63:0] a;
        logic [63:0] w;
        int n;
        d = '0;
        n = modelBytes();
        for (int i = 0; i < n; i++) begin
            a = m_pc + 64'(i);
            w = wordAt(a);
            d[8*i +: 8] = w[8*a[2:0] +: 8];
        end
        return d;
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        imem_addr_ready = 1'b0;
        imem_data_valid = 1'b0;
        imem_data = '0;
        {advance16, advance32, advance64} = 3'b000;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        #1;
        checkOutput("reset_addr_valid", 64'(imem_addr_valid), 64'd0);
        checkOutput("reset_inst_bytes", 64'(inst_bytes), 64'd0);
        checkOutput("reset_instData", instData, 64'd0);
        checkOutput("reset_adv_err", 64'(adv_err), 64'd0);
        checkOutput("reset_inst_pc", inst_pc, RESET_PC);
        pending.delete();
        m_pc = RESET_PC;
        m_buf_end = RESET_PC & ~64'h7;
        m_fetch = RESET_PC & ~64'h7;
        m_inflight = 0;
        m_drop = 0;
        m_err = 1'b0;
        rst_n = 1'b1;
    endtask

    // One cycle: drive inputs after the edge, check outputs, advance the model.
    task automatic applyStimulus(input bit ready, input bit a16, input bit a32, input bit a64,
                                 input bit redir, input logic [63:0] rpc);
        bit dv;
        bit expv;
        int nb;
        int n;
        int s;
        dv = (pending.size() > 0) && (pending[0].due <= cyc);
        imem_data_valid = dv;
        imem_data = dv ? wordAt(pending[0].addr) : {$urandom, $urandom};
        imem_addr_ready = ready;
        advance16 = a16;
        advance32 = a32;
        advance64 = a64;
        redirect_valid = redir;
        redirect_pc = rpc;
        #2;
        nb = modelBytes();
        expv = !redir && (modelWords() + m_inflight < DEPTH) && (m_inflight < MAX_OUT);
        checkOutput("imem_addr_valid", 64'(imem_addr_valid), 64'(expv));
        if (expv) checkOutput("imem_addr", imem_addr, m_fetch);
        checkOutput("inst_bytes", 64'(inst_bytes), 64'(nb));
        checkOutput("inst_pc", inst_pc, m_pc);
        checkOutput("instData", instData, modelData());
        checkOutput("adv_err", 64'(adv_err), 64'(m_err));

        if (dv) void'(pending.pop_front());
        if (expv && ready) begin
            pending.push_back('{addr: m_fetch, due: cyc + 1 + (rand_lat ? $urandom_range(0, 2) : 0)});
        end
        if (redir) begin
            m_inflight = m_inflight - int'(dv);
            m_drop = m_inflight;
            m_pc = rpc & ~64'h1;
            m_fetch = rpc & ~64'h7;
            m_buf_end = m_fetch;
            m_err = 1'b0;
        end else begin
            n = int'(a16) + int'(a32) + int'(a64);
            s = a64 ? 8 : (a32 ? 4 : 2);
            m_err = (n > 1) || (n == 1 && s > nb);
            if (n == 1 && s <= nb) m_pc = m_pc + 64'(s);
            if (dv) begin
                m_inflight--;
                if (m_drop > 0) m_drop--;
                else m_buf_end = m_buf_end + 64'd8;
            end
            if (expv && ready) begin
                m_fetch = m_fetch + 64'd8;
                m_inflight++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic randomPhase(input int cycles);
        int r;
        int mb;
        int pick;
        bit a16, a32, a64, redir;
        logic [63:0] rpc;
        for (int k = 0; k < cycles; k++) begin
            r = $urandom_range(0, 99);
            mb = modelBytes();
            {a16, a32, a64} = 3'b000;
            if (r < 55) begin
                pick = $urandom_range(0, 2);
                if ($urandom_range(0, 4) != 0) begin
                    if (mb >= 8) pick = $urandom_range(0, 2);
                    else if (mb >= 4) pick = $urandom_range(0, 1);
                    else pick = 0;
                end
                a16 = (pick == 0);
                a32 = (pick == 1);
                a64 = (pick == 2);
            end else if (r < 60) begin
                a16 = 1'b1;
                a32 = $urandom_range(0, 1) == 1;
                a64 = !a32 || ($urandom_range(0, 1) == 1);
            end
            redir = $urandom_range(0, 99) < 4;
            case ($urandom_range(0, 2))
                0:       rpc = 64'($urandom_range(0, 1023));
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: rpc = {$urandom, $urandom};
            endcase
            applyStimulus($urandom_range(0, 3) != 0, a16, a32, a64, redir, rpc);
        end
    endtask

    initial begin
        doReset();
        // Fill the queue with no consumption, then step through the window.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Redirect with requests outstanding, then drain and consume to the boundary.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h106);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        rand_lat = 1'b1;
        randomPhase(2500);
        doReset();
        randomPhase(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
